apb_spi_fifo_rf: RTL and testbench
==================================

// Module: apb_spi_fifo_rf
// PURPOSE
//  APB register file for the SPI master, with parametrised TX and RX FIFOs in place of single-entry registers.
//  Software queues several command frames and drains several read words without waiting for each transfer.
//  Adds status and level reporting, sticky error flags, an EOT counter, FIFO flush and an interrupt output.
//  Sits between the APB slave bus and the SPI stream engine.
// PARAMETERS
//  TX_DEPTH  8  TX FIFO entries; power of 2, >=2
//  RX_DEPTH  8  RX FIFO entries; power of 2, >=2
//  DIV_RST   1  reset value of CTRL.div (16b); a div of 0 always reads back and drives as 1
// PORTS
//  pclk_i                 in   1   single clock
//  rst_i                  in   1   reset, synchronous, active-high
//  psel_i/penable_i       in   1   APB select / enable
//  paddr_i                in   4   word register index
//  pwrite_i               in   1   APB write
//  pwdata_i               in   32  APB write data
//  prdata_o               out  32  APB read data
//  pready_o               out  1   tied 1
//  pslverr_o              out  1   access error (see below)
//  spi_clk_div_vld_o      out  1   tied 1
//  spi_clk_div_o          out  16  CTRL.div, 0 mapped to 1
//  eot_i                  in   1   end-of-transfer pulse
//  stream_data_tx_o       out  32  TX FIFO head {cmd[3:0],addr[3:0],len[7:0],wdata[15:0]}
//  stream_data_tx_vld_o   out  1   CTRL.tx_en & !tx_empty
//  stream_data_tx_rdy_i   in   1   engine accepts the head
//  stream_data_rx_i       in   32  received word
//  stream_data_rx_vld_i   in   1   received word valid
//  stream_data_rx_rdy_o   out  1   CTRL.rx_en & !rx_full
//  irq_o                  out  1   registered interrupt
// BEHAVIOUR
//  Access strobes: wr = psel&penable&pwrite; rd = psel&penable&!pwrite. One-cycle access.
//  prdata_o is combinational from paddr_i when rd, else 0. Unmapped reads return 0.
//  Map:
//   0 CMD, 1 ADDR, 2 LEN: RW staging registers.
//   3 WDATA: write pushes the frame {CMD,ADDR,LEN,pwdata[15:0]}; read returns the last written value.
//   4 RDATA: read pops the RX head.
//   5 CTRL: [0] tx_en, [1] rx_en, [2] irq_en, [3] flush (write-1, self-clearing, reads 0), [31:16] div.
//   6 STATUS: RO except W1C bits.
//     [0] tx_empty  [1] tx_full  [2] rx_empty  [3] rx_full
//     [4] tx_ovf (W1C)  [5] rx_udf (W1C)
//     [15:8] eot_cnt (saturating at 255; any write to STATUS zeroes it)
//     [23:16] tx_level  [31:24] rx_level
//  TX push while tx_full: frame dropped, pslverr_o=1, tx_ovf set.
//    Fullness is sampled before a same-cycle pop, so a full FIFO rejects the push even if it pops that cycle.
//  RDATA read while rx_empty: returns 0, pslverr_o=1, rx_udf set.
//  Otherwise pslverr_o=0. On a hit, the RX pop takes effect at the end of the access cycle.
//  TX pop on vld&rdy_i. RX push on rx_vld_i & rx_rdy_o; a word offered while not ready is not taken (no loss).
//  Push and pop in the same cycle on a non-full, non-empty FIFO: level unchanged.
//  Flush: both FIFOs are empty the next cycle. It beats any same-cycle push or pop, and error flags are kept.
//  Unlike the previous block, eot_i does NOT clear tx_en/rx_en; eot_i only increments eot_cnt.
//  irq_o (registered, one-cycle latency) = irq_en & (!rx_empty | tx_empty | tx_ovf | rx_udf).
//  Reset: all registers 0 except div=DIV_RST; FIFOs empty.
//    Outputs at reset: irq_o=0, tx_vld=0, rx_rdy=0, pslverr=0.
//    Reset in mid-transfer discards all FIFO contents.
//  Level counters are $clog2(DEPTH)+1 bits wide, zero-extended into the 8-bit STATUS fields.
// STRUCTURE
//  Shared package: register index constants, CTRL/STATUS bit positions, TX frame field offsets.
//  One sub-module, spi_sync_fifo (WIDTH, DEPTH).
//    Ports: push, pop, flush, full, empty, level. Head is combinational, with no fall-through.
//    Instantiated twice (TX 32b, RX 32b).
// TESTING
//  1 Reset, then read CTRL and STATUS -> CTRL=0x0001_0000; STATUS=0x0000_0005; irq_o=0.
//  2 CMD=1, ADDR=2, LEN=4, then WDATA=0xBEEF x3 with tx_en=1 and rdy held 0.
//    -> tx_level=3; stream_data_tx_o=0x1204_BEEF.
//    Raise rdy for 3 cycles -> tx_empty=1, tx_vld=0.
//  3 Fill TX with 8 frames, then a 9th write -> pslverr=1, tx_ovf=1, level stays 8.
//    Write STATUS=0x10 -> tx_ovf=0.
//  4 rx_en=1; push RX words 0xA0..0xA8 with rx_vld held -> rdy drops after 8, 9th word held.
//    Pop once -> reads 0xA0 and the 9th word is accepted the next cycle.
//  5 RDATA read while rx_empty -> prdata=0, pslverr=1, rx_udf=1.
//    With irq_en=1, irq_o=1 one cycle later.
//  6 Flush with 5 TX and 3 RX entries and a simultaneous rx push -> both levels 0 the next cycle.
//    3 eot_i pulses -> eot_cnt=3.

Source files
------------

// File: rtl/apb_spi_fifo_rf_pkg.sv
// Shared definitions for the SPI master APB register file.
// Holds the register word indices, CTRL/STATUS bit positions, TX frame
// field offsets and a helper that packs a command frame.
package apb_spi_fifo_rf_pkg;

  localparam int ADDR_W = 4;

  // Register word indices
  localparam logic [ADDR_W-1:0] REG_CMD    = 4'd0;
  localparam logic [ADDR_W-1:0] REG_ADDR   = 4'd1;
  localparam logic [ADDR_W-1:0] REG_LEN    = 4'd2;
  localparam logic [ADDR_W-1:0] REG_WDATA  = 4'd3;
  localparam logic [ADDR_W-1:0] REG_RDATA  = 4'd4;
  localparam logic [ADDR_W-1:0] REG_CTRL   = 4'd5;
  localparam logic [ADDR_W-1:0] REG_STATUS = 4'd6;

  // CTRL bit positions
  localparam int CTRL_TX_EN   = 0;
  localparam int CTRL_RX_EN   = 1;
  localparam int CTRL_IRQ_EN  = 2;
  localparam int CTRL_FLUSH   = 3;
  localparam int CTRL_DIV_LSB = 16;

  // STATUS W1C bit positions
  localparam int STAT_TX_OVF = 4;
  localparam int STAT_RX_UDF = 5;

  // TX frame field offsets
  localparam int FRAME_CMD_LSB  = 28;
  localparam int FRAME_ADDR_LSB = 24;
  localparam int FRAME_LEN_LSB  = 16;

  function automatic logic [31:0] pack_frame(input logic [3:0]  cmd,
                                             input logic [3:0]  addr,
                                             input logic [7:0]  len,
                                             input logic [15:0] wdata);
    logic [31:0] f;
    f = '0;
    f[FRAME_CMD_LSB  +: 4] = cmd;
    f[FRAME_ADDR_LSB +: 4] = addr;
    f[FRAME_LEN_LSB  +: 8] = len;
    f[15:0]                = wdata;
    return f;
  endfunction

endpackage

// File: rtl/apb_spi_fifo_rf_if.sv
// APB slave bus bundle for the SPI register file.
// master: drives psel/penable/paddr/pwrite/pwdata, samples prdata/pready/pslverr.
// slave : the reverse.
interface apb_spi_fifo_rf_if import apb_spi_fifo_rf_pkg::*; ();
  logic              psel;
  logic              penable;
  logic [ADDR_W-1:0] paddr;
  logic              pwrite;
  logic [31:0]       pwdata;
  logic [31:0]       prdata;
  logic              pready;
  logic              pslverr;

  modport master (output psel, penable, paddr, pwrite, pwdata,
                  input  prdata, pready, pslverr);
  modport slave  (input  psel, penable, paddr, pwrite, pwdata,
                  output prdata, pready, pslverr);
endinterface

// File: rtl/apb_spi_fifo_rf_sync_fifo.sv
// spi_sync_fifo: single-clock FIFO with flush and level reporting.
// Ports: clk, rst (sync, active-high), push/din, pop, flush, head (combinational
// read of the oldest entry, no fall-through), full, empty, level.
// A push while full and a pop while empty are ignored; flush beats both.
module spi_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // Fullness is judged on the registered level, so a full FIFO refuses a
  // push even when it pops in the same cycle.
  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Pointer and level bookkeeping; flush returns the FIFO to empty.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset: the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/apb_spi_fifo_rf.sv
// apb_spi_fifo_rf: APB register file for the SPI master with TX/RX FIFOs.
// Ports: pclk_i/rst_i (sync active-high), apb (slave modport), eot_i,
// spi clock divider outputs, TX stream (data/vld out, rdy in), RX stream
// (data/vld in, rdy out) and the registered interrupt irq_o.
module apb_spi_fifo_rf
  import apb_spi_fifo_rf_pkg::*;
#(
  parameter int          TX_DEPTH = 8,
  parameter int          RX_DEPTH = 8,
  parameter logic [15:0] DIV_RST  = 16'd1
) (
  input  logic                 pclk_i,
  input  logic                 rst_i,
  apb_spi_fifo_rf_if.slave     apb,
  output logic                 spi_clk_div_vld_o,
  output logic [15:0]          spi_clk_div_o,
  input  logic                 eot_i,
  output logic [31:0]          stream_data_tx_o,
  output logic                 stream_data_tx_vld_o,
  input  logic                 stream_data_tx_rdy_i,
  input  logic [31:0]          stream_data_rx_i,
  input  logic                 stream_data_rx_vld_i,
  output logic                 stream_data_rx_rdy_o,
  output logic                 irq_o
);
  logic wr, rd;
  logic [3:0]  cmd_q, addr_q;
  logic [7:0]  len_q, eot_cnt_q;
  logic [31:0] wdata_q;
  logic [15:0] div_q, div_eff;
  logic tx_en_q, rx_en_q, irq_en_q, tx_ovf_q, rx_udf_q, irq_q;
  logic tx_push, tx_pop, tx_full, tx_empty;
  logic rx_push, rx_pop, rx_full, rx_empty;
  logic tx_ovf_evt, rx_udf_evt, flush, status_wr;
  logic [31:0] tx_head, rx_head, status_word;
  logic [$clog2(TX_DEPTH):0] tx_level;
  logic [$clog2(RX_DEPTH):0] rx_level;

  assign wr = apb.psel & apb.penable &  apb.pwrite;
  assign rd = apb.psel & apb.penable & ~apb.pwrite;

  assign tx_push    = wr && (apb.paddr == REG_WDATA);
  assign tx_ovf_evt = tx_push & tx_full;
  assign rx_pop     = rd && (apb.paddr == REG_RDATA);
  assign rx_udf_evt = rx_pop & rx_empty;
  assign flush      = wr && (apb.paddr == REG_CTRL) && apb.pwdata[CTRL_FLUSH];
  assign status_wr  = wr && (apb.paddr == REG_STATUS);

  assign div_eff              = (div_q == 16'd0) ? 16'd1 : div_q;
  assign spi_clk_div_o        = div_eff;
  assign spi_clk_div_vld_o    = 1'b1;
  assign apb.pready           = 1'b1;
  assign apb.pslverr          = tx_ovf_evt | rx_udf_evt;
  assign stream_data_tx_o     = tx_head;
  assign stream_data_tx_vld_o = tx_en_q & ~tx_empty;
  assign tx_pop               = stream_data_tx_vld_o & stream_data_tx_rdy_i;
  assign stream_data_rx_rdy_o = rx_en_q & ~rx_full;
  assign rx_push              = stream_data_rx_vld_i & stream_data_rx_rdy_o;
  assign irq_o                = irq_q;

  spi_sync_fifo #(.WIDTH(32), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(pclk_i), .rst(rst_i), .push(tx_push),
    .din(pack_frame(cmd_q, addr_q, len_q, apb.pwdata[15:0])),
    .pop(tx_pop), .flush(flush), .head(tx_head),
    .full(tx_full), .empty(tx_empty), .level(tx_level)
  );

  spi_sync_fifo #(.WIDTH(32), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(pclk_i), .rst(rst_i), .push(rx_push), .din(stream_data_rx_i),
    .pop(rx_pop), .flush(flush), .head(rx_head),
    .full(rx_full), .empty(rx_empty), .level(rx_level)
  );

  assign status_word = {8'(rx_level), 8'(tx_level), eot_cnt_q, 2'b00,
                        rx_udf_q, tx_ovf_q, rx_full, rx_empty, tx_full, tx_empty};

  // Software-visible registers. A STATUS write zeroes the EOT counter even
  // if eot_i pulses in the same cycle.
  always_ff @(posedge pclk_i) begin
    if (rst_i) begin
      cmd_q     <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      wdata_q   <= '0;
      tx_en_q   <= 1'b0;
      rx_en_q   <= 1'b0;
      irq_en_q  <= 1'b0;
      div_q     <= DIV_RST;
      tx_ovf_q  <= 1'b0;
      rx_udf_q  <= 1'b0;
      eot_cnt_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      if (wr && apb.paddr == REG_CMD)   cmd_q   <= apb.pwdata[3:0];
      if (wr && apb.paddr == REG_ADDR)  addr_q  <= apb.pwdata[3:0];
      if (wr && apb.paddr == REG_LEN)   len_q   <= apb.pwdata[7:0];
      if (tx_push)                      wdata_q <= apb.pwdata;
      if (wr && apb.paddr == REG_CTRL) begin
        tx_en_q  <= apb.pwdata[CTRL_TX_EN];
        rx_en_q  <= apb.pwdata[CTRL_RX_EN];
        irq_en_q <= apb.pwdata[CTRL_IRQ_EN];
        div_q    <= apb.pwdata[CTRL_DIV_LSB +: 16];
      end
      if (tx_ovf_evt)
        tx_ovf_q <= 1'b1;
      else if (status_wr && apb.pwdata[STAT_TX_OVF])
        tx_ovf_q <= 1'b0;
      if (rx_udf_evt)
        rx_udf_q <= 1'b1;
      else if (status_wr && apb.pwdata[STAT_RX_UDF])
        rx_udf_q <= 1'b0;
      if (status_wr)
        eot_cnt_q <= '0;
      else if (eot_i && eot_cnt_q != 8'hFF)
        eot_cnt_q <= eot_cnt_q + 8'd1;
      irq_q <= irq_en_q & (~rx_empty | tx_empty | tx_ovf_q | rx_udf_q);
    end
  end

  // Read mux; only drives data during a read access.
  always_comb begin
    apb.prdata = '0;
    if (rd) begin
      case (apb.paddr)
        REG_CMD:    apb.prdata = {28'd0, cmd_q};
        REG_ADDR:   apb.prdata = {28'd0, addr_q};
        REG_LEN:    apb.prdata = {24'd0, len_q};
        REG_WDATA:  apb.prdata = wdata_q;
        REG_RDATA:  apb.prdata = rx_empty ? 32'd0 : rx_head;
        REG_CTRL:   apb.prdata = {div_eff, 13'd0, irq_en_q, rx_en_q, tx_en_q};
        REG_STATUS: apb.prdata = status_word;
        default:    apb.prdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_spi_fifo_rf.sv
// Directed self-checking bench for apb_spi_fifo_rf with TX/RX scoreboards.
module tb_apb_spi_fifo_rf;
  import apb_spi_fifo_rf_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        eot = 1'b0;
  logic        tx_rdy = 1'b0;
  logic [31:0] rx_data = '0;
  logic        rx_vld = 1'b0;
  logic        div_vld, tx_vld, rx_rdy, irq;
  logic [15:0] div;
  logic [31:0] tx_data;

  int errors = 0;
  int checks = 0;
  logic [31:0] tx_exp_q[$];
  logic [31:0] rx_exp_q[$];

  apb_spi_fifo_rf_if bus ();

  apb_spi_fifo_rf dut (
    .pclk_i(clk), .rst_i(rst), .apb(bus.slave),
    .spi_clk_div_vld_o(div_vld), .spi_clk_div_o(div), .eot_i(eot),
    .stream_data_tx_o(tx_data), .stream_data_tx_vld_o(tx_vld),
    .stream_data_tx_rdy_i(tx_rdy), .stream_data_rx_i(rx_data),
    .stream_data_rx_vld_i(rx_vld), .stream_data_rx_rdy_o(rx_rdy),
    .irq_o(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One APB transfer: setup cycle, access cycle (sampled at its negedge).
  // rx_pulse offers an RX word only during the access cycle.
  task automatic applyStimulus(input logic w, input logic [3:0] a, input logic [31:0] d,
                               input logic rx_pulse, input logic [31:0] rx_word,
                               output logic [31:0] rdata, output logic err);
    @(posedge clk); #1;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = w; bus.paddr = a; bus.pwdata = d;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    if (rx_pulse) begin rx_vld = 1'b1; rx_data = rx_word; end
    @(negedge clk);
    rdata = bus.prdata; err = bus.pslverr;
    @(posedge clk); #1;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    if (rx_pulse) rx_vld = 1'b0;
  endtask

  task automatic apbWrite(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] r; logic e;
    applyStimulus(1'b1, a, d, 1'b0, 32'h0, r, e);
  endtask

  task automatic apbRead(input logic [3:0] a, output logic [31:0] r, output logic e);
    applyStimulus(1'b0, a, 32'h0, 1'b0, 32'h0, r, e);
  endtask

  task automatic drainTx(input int n);
    int got; int cyc; logic [31:0] exp;
    got = 0; cyc = 0;
    @(posedge clk); #1 tx_rdy = 1'b1;
    while (got < n && cyc < 50) begin
      @(negedge clk);
      if (tx_vld) begin
        exp = (tx_exp_q.size() > 0) ? tx_exp_q.pop_front() : 32'hDEAD_DEAD;
        checkOutput("tx_frame", tx_data, exp);
        got++;
      end
      cyc++;
      @(posedge clk); #1;
    end
    tx_rdy = 1'b0;
    checkOutput("tx_drain_count", 32'(got), 32'(n));
  endtask

  task automatic drainRx(input int n);
    logic [31:0] r, exp; logic e;
    for (int i = 0; i < n; i++) begin
      exp = (rx_exp_q.size() > 0) ? rx_exp_q.pop_front() : 32'hDEAD_DEAD;
      apbRead(REG_RDATA, r, e);
      checkOutput("rx_word", r, exp);
      checkOutput("rx_word_err", {31'd0, e}, 32'd0);
    end
  endtask

  initial begin
    logic [31:0] r;
    logic        e;
    int          k;
    int          cyc;

    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.paddr = '0; bus.pwdata = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_irq", {31'd0, irq}, 32'd0);
    checkOutput("rst_tx_vld", {31'd0, tx_vld}, 32'd0);
    checkOutput("rst_rx_rdy", {31'd0, rx_rdy}, 32'd0);
    checkOutput("rst_pslverr", {31'd0, bus.pslverr}, 32'd0);
    checkOutput("rst_div", {16'd0, div}, 32'd1);
    apbRead(REG_CTRL, r, e);
    checkOutput("rst_ctrl", r, 32'h0001_0000);
    apbRead(REG_STATUS, r, e);
    checkOutput("rst_status", r, 32'h0000_0005);

    // Queue three frames with the engine stalled
    apbWrite(REG_CMD, 32'd1);
    apbWrite(REG_ADDR, 32'd2);
    apbWrite(REG_LEN, 32'd4);
    apbWrite(REG_CTRL, 32'h0001_0001);
    for (int i = 0; i < 3; i++) begin
      apbWrite(REG_WDATA, 32'h0000_BEEF);
      tx_exp_q.push_back(32'h1204_BEEF);
    end
    apbRead(REG_STATUS, r, e);
    checkOutput("tx_level3", {24'd0, r[23:16]}, 32'd3);
    @(negedge clk);
    checkOutput("tx_head", tx_data, 32'h1204_BEEF);
    checkOutput("tx_vld_on", {31'd0, tx_vld}, 32'd1);
    apbRead(REG_WDATA, r, e);
    checkOutput("wdata_readback", r, 32'h0000_BEEF);
    drainTx(3);
    @(negedge clk);
    checkOutput("tx_vld_off", {31'd0, tx_vld}, 32'd0);
    apbRead(REG_STATUS, r, e);
    checkOutput("tx_empty_after_drain", r, 32'h0000_0005);

    // TX overflow
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, REG_WDATA, 32'h100 + 32'(i), 1'b0, 32'h0, r, e);
      checkOutput("tx_push_ok", {31'd0, e}, 32'd0);
      tx_exp_q.push_back(32'h1204_0100 + 32'(i));
    end
    applyStimulus(1'b1, REG_WDATA, 32'h0000_0108, 1'b0, 32'h0, r, e);
    checkOutput("tx_ovf_pslverr", {31'd0, e}, 32'd1);
    apbRead(REG_STATUS, r, e);
    checkOutput("tx_ovf_status", r, 32'h0008_0016);
    apbWrite(REG_STATUS, 32'h0000_0010);
    apbRead(REG_STATUS, r, e);
    checkOutput("tx_ovf_w1c", r, 32'h0008_0006);
    drainTx(8);

    // RX fill with backpressure
    apbWrite(REG_CTRL, 32'h0001_0003);
    k = 0; cyc = 0;
    @(posedge clk); #1;
    rx_vld = 1'b1; rx_data = 32'hA0;
    while (k < 8 && cyc < 40) begin
      @(negedge clk);
      if (rx_rdy) begin rx_exp_q.push_back(rx_data); k++; end
      cyc++;
      @(posedge clk); #1;
      rx_data = 32'hA0 + 32'(k);
    end
    checkOutput("rx_fill_count", 32'(k), 32'd8);
    @(negedge clk);
    checkOutput("rx_rdy_full", {31'd0, rx_rdy}, 32'd0);
    apbRead(REG_STATUS, r, e);
    checkOutput("rx_full_status", r, 32'h0800_0009);
    apbRead(REG_RDATA, r, e);
    checkOutput("rx_first_pop", r, (rx_exp_q.size() > 0) ? rx_exp_q.pop_front() : 32'hDEAD_DEAD);
    @(negedge clk);
    checkOutput("rx_rdy_after_pop", {31'd0, rx_rdy}, 32'd1);
    if (rx_rdy) rx_exp_q.push_back(rx_data);
    @(posedge clk); #1 rx_vld = 1'b0;
    apbRead(REG_STATUS, r, e);
    checkOutput("rx_refill_status", r, 32'h0800_0009);
    drainRx(8);
    apbRead(REG_STATUS, r, e);
    checkOutput("rx_drained_status", r, 32'h0000_0005);

    // RX underflow and interrupt latency
    apbRead(REG_RDATA, r, e);
    checkOutput("rx_udf_data", r, 32'd0);
    checkOutput("rx_udf_pslverr", {31'd0, e}, 32'd1);
    apbRead(REG_STATUS, r, e);
    checkOutput("rx_udf_status", r, 32'h0000_0025);
    apbWrite(REG_CTRL, 32'h0000_0007);
    @(negedge clk);
    checkOutput("irq_latency0", {31'd0, irq}, 32'd0);
    @(negedge clk);
    checkOutput("irq_latency1", {31'd0, irq}, 32'd1);
    checkOutput("div_zero_maps_1", {16'd0, div}, 32'd1);
    apbRead(REG_CTRL, r, e);
    checkOutput("ctrl_div0_readback", r, 32'h0001_0007);
    apbWrite(REG_STATUS, 32'h0000_0020);
    apbRead(REG_STATUS, r, e);
    checkOutput("rx_udf_w1c", r, 32'h0000_0005);

    // Flush with a simultaneous RX push
    for (int i = 0; i < 5; i++) apbWrite(REG_WDATA, 32'h200 + 32'(i));
    @(posedge clk); #1 rx_vld = 1'b1;
    for (int j = 0; j < 3; j++) begin
      rx_data = 32'hC0 + 32'(j);
      @(posedge clk); #1;
    end
    rx_vld = 1'b0;
    apbRead(REG_STATUS, r, e);
    checkOutput("pre_flush_levels", r, 32'h0305_0000);
    applyStimulus(1'b1, REG_CTRL, 32'h0000_000F, 1'b1, 32'hD0, r, e);
    apbRead(REG_STATUS, r, e);
    checkOutput("post_flush_status", r, 32'h0000_0005);
    apbRead(REG_CTRL, r, e);
    checkOutput("flush_self_clear", r, 32'h0001_0007);
    tx_exp_q.delete();
    rx_exp_q.delete();

    // EOT counter
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1 eot = 1'b1;
      @(posedge clk); #1 eot = 1'b0;
    end
    apbRead(REG_STATUS, r, e);
    checkOutput("eot_cnt3", r, 32'h0000_0305);
    apbWrite(REG_STATUS, 32'h0);
    apbRead(REG_STATUS, r, e);
    checkOutput("eot_cnt_clear", r, 32'h0000_0005);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
